// File: rtl/srff_bank_arbiter.sv
// Round-robin arbiter granting NREQ requesters access to a shared bank of WIDTH
// SR flip-flops; each grant captures the winner's set/reset masks and applies them once.
module srff_bank_arbiter #(
  parameter int NREQ  = 3,
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  clear_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] s_vec,
  input  logic [NREQ*WIDTH-1:0] r_vec,
  input  logic                  force_clr,
  input  logic                  force_pre,
  output logic [WIDTH-1:0]      q,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       ack,
  output logic                  err,
  output logic                  busy,
  output logic [1:0]            fsm_state
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    APPLY = 2'd2,
    ACK   = 2'd3
  } state_t;

  // Handshake: req is a level held until ack; ack pulses one cycle in ACK while gnt is high.
  state_t           state, state_nxt;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    win_q, win_c;
  logic             found;
  logic [WIDTH-1:0] s_cap, r_cap;
  logic [WIDTH-1:0] q_upd;

  assign busy      = (state != IDLE);
  assign fsm_state = state;

  // Round-robin search starting at ptr, wrapping modulo NREQ.
  always_comb begin
    win_c = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      int idx;
      idx = (int'(ptr) + i) % NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win_c = PW'(idx);
      end
    end
  end

  // s=r=1 bits hold, so set applies only where r is clear and vice versa.
  assign q_upd = (q | (s_cap & ~r_cap)) & ~(r_cap & ~s_cap);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = GRANT;
      GRANT:   state_nxt = req[win_q] ? APPLY : IDLE;
      APPLY:   state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      gnt   <= '0;
      ack   <= '0;
      err   <= 1'b0;
      ptr   <= '0;
      win_q <= '0;
      s_cap <= '0;
      r_cap <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            gnt   <= NREQ'(1) << win_c;
            win_q <= win_c;
            s_cap <= s_vec[int'(win_c)*WIDTH +: WIDTH];
            r_cap <= r_vec[int'(win_c)*WIDTH +: WIDTH];
          end
        end
        GRANT: begin
          if (!req[win_q]) gnt <= '0;
        end
        APPLY: begin
          ack <= NREQ'(1) << win_q;
          err <= |(s_cap & r_cap);
        end
        ACK: begin
          gnt <= '0;
          ack <= '0;
          err <= 1'b0;
          if (int'(win_q) == NREQ - 1) ptr <= '0;
          else                         ptr <= win_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Force commands take priority over the mask update but leave the FSM alone.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n)            q <= '0;
    else if (force_clr)      q <= '0;
    else if (force_pre)      q <= '1;
    else if (state == APPLY) q <= q_upd;
  end

endmodule

// File: tb/tb_srff_bank_arbiter.sv
// Bench for srff_bank_arbiter: directed vector table, hand sequences for
// abandon/force/reset corners, and random transactions against a behavioural model.
module tb_srff_bank_arbiter;

  localparam int NREQ  = 3;
  localparam int WIDTH = 4;

  logic                  clk = 1'b0;
  logic                  clear_n;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] s_vec, r_vec;
  logic                  force_clr, force_pre;
  logic [WIDTH-1:0]      q;
  logic [NREQ-1:0]       gnt, ack;
  logic                  err, busy;
  logic [1:0]            fsm_state;

  int errors = 0;
  int checks = 0;
  bit running = 1'b0;

  srff_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk(clk), .clear_n(clear_n), .req(req), .s_vec(s_vec), .r_vec(r_vec),
    .force_clr(force_clr), .force_pre(force_pre), .q(q), .gnt(gnt), .ack(ack),
    .err(err), .busy(busy), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // gnt one-hot and ack only with its gnt bit, every cycle.
  always @(negedge clk) begin
    if (running && clear_n) begin
      checks++;
      if (!$onehot0(gnt) || ((ack & ~gnt) != '0)) begin
        errors++;
        $display("FAIL onehot: gnt=%b ack=%b at %0t", gnt, ack, $time);
      end
    end
  end

  // One full transaction; fcmd = {force_clr, force_pre} applied during APPLY.
  task automatic run_txn(input logic [2:0] rq, input logic [11:0] s, input logic [11:0] r,
                         input logic [2:0] eg, input logic [3:0] eq, input logic ee,
                         input bit scramble, input logic [1:0] fcmd);
    req = rq; s_vec = s; r_vec = r;
    tick();
    chk("gnt", 32'(gnt), 32'(eg));
    chk("busy_grant", 32'(busy), 32'd1);
    if (scramble) begin
      s_vec = 12'($urandom);
      r_vec = 12'($urandom);
    end
    tick();
    chk("ack_apply", 32'(ack), 32'd0);
    force_clr = fcmd[1];
    force_pre = fcmd[0];
    tick();
    force_clr = 1'b0;
    force_pre = 1'b0;
    chk("q", 32'(q), 32'(eq));
    chk("ack", 32'(ack), 32'(eg));
    chk("err", 32'(err), 32'(ee));
    chk("gnt_ack", 32'(gnt), 32'(eg));
    req = '0;
    tick();
    chk("busy_idle", 32'(busy), 32'd0);
    chk("gnt_idle", 32'(gnt), 32'd0);
    chk("ack_idle", 32'(ack), 32'd0);
    chk("err_idle", 32'(err), 32'd0);
  endtask

  typedef struct {
    logic [2:0]  rq;
    logic [11:0] s;
    logic [11:0] r;
    logic        pre;
    logic [2:0]  eg;
    logic [3:0]  eq;
    logic        ee;
  } vec_t;

  vec_t vt[7];

  // Behavioural model state for the random phase.
  int         ptr_m;
  logic [3:0] q_m;

  initial begin
    vt[0] = '{3'b001, 12'b0000_0000_1010, 12'h000, 1'b0, 3'b001, 4'b1010, 1'b0};
    vt[1] = '{3'b111, 12'b1000_0100_0001, 12'h000, 1'b0, 3'b010, 4'b1110, 1'b0};
    vt[2] = '{3'b111, 12'b1000_0100_0001, 12'h000, 1'b0, 3'b100, 4'b1110, 1'b0};
    vt[3] = '{3'b111, 12'b1000_0100_0001, 12'h000, 1'b0, 3'b001, 4'b1111, 1'b0};
    vt[4] = '{3'b010, 12'b0000_0011_0000, 12'b0000_0110_0000, 1'b1, 3'b010, 4'b1011, 1'b1};
    vt[5] = '{3'b101, 12'b0100_0000_0000, 12'b0000_0000_1111, 1'b0, 3'b100, 4'b1111, 1'b0};
    vt[6] = '{3'b110, 12'h000, 12'b0000_0011_0000, 1'b0, 3'b010, 4'b1100, 1'b0};

    clear_n = 1'b0; req = '0; s_vec = '0; r_vec = '0; force_clr = 1'b0; force_pre = 1'b0;
    #3;
    chk("rst_q", 32'(q), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    tick();
    tick();
    clear_n = 1'b1;
    running = 1'b1;
    tick();
    chk("idle_no_req", 32'(busy), 32'd0);

    for (int i = 0; i < 7; i++) begin
      if (vt[i].pre) begin
        force_pre = 1'b1;
        tick();
        force_pre = 1'b0;
        chk("preset", 32'(q), 32'hf);
      end
      run_txn(vt[i].rq, vt[i].s, vt[i].r, vt[i].eg, vt[i].eq, vt[i].ee, 1'b0, 2'b00);
    end

    // Reset during APPLY: outputs drop at once, command discarded.
    req = 3'b001; s_vec = 12'hfff; r_vec = '0;
    tick();
    tick();
    clear_n = 1'b0;
    #1;
    chk("arst_q", 32'(q), 32'd0);
    chk("arst_gnt", 32'(gnt), 32'd0);
    chk("arst_ack", 32'(ack), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    req = '0;
    tick();
    clear_n = 1'b1;
    tick();
    chk("arst_no_ack", 32'(ack), 32'd0);
    chk("arst_q_hold", 32'(q), 32'd0);

    // Abandon in GRANT: ptr must stay at 0.
    req = 3'b001; s_vec = 12'h00f;
    tick();
    chk("abn_gnt", 32'(gnt), 32'b001);
    req = '0;
    tick();
    chk("abn_gnt_clr", 32'(gnt), 32'd0);
    chk("abn_busy", 32'(busy), 32'd0);
    tick();
    chk("abn_no_ack", 32'(ack), 32'd0);
    chk("abn_q", 32'(q), 32'd0);
    run_txn(3'b011, 12'b0000_0000_0101, 12'h000, 3'b001, 4'b0101, 1'b0, 1'b0, 2'b00);

    // Both forces during APPLY: clear wins, ack still pulses, ptr advances to 2.
    run_txn(3'b010, 12'b0000_1111_0000, 12'h000, 3'b010, 4'b0000, 1'b0, 1'b0, 2'b11);
    run_txn(3'b011, 12'b0000_0000_0110, 12'h000, 3'b001, 4'b0110, 1'b0, 1'b0, 2'b00);

    // Random phase: ptr is now 1, q is 0110.
    ptr_m = 1;
    q_m   = 4'b0110;
    for (int n = 0; n < 60; n++) begin
      logic [2:0]  rq;
      logic [11:0] s, r;
      logic [3:0]  sw, rw;
      logic [1:0]  pre_f, app_f;
      int          w;
      logic        ee;
      pre_f = 2'($urandom_range(0, 3));
      if (pre_f != 2'b00 && $urandom_range(0, 2) == 0) begin
        force_clr = pre_f[1];
        force_pre = pre_f[0];
        tick();
        force_clr = 1'b0;
        force_pre = 1'b0;
        q_m = pre_f[1] ? 4'h0 : 4'hf;
        chk("rnd_force", 32'(q), 32'(q_m));
      end
      rq = 3'($urandom_range(1, 7));
      s  = 12'($urandom);
      r  = 12'($urandom);
      w  = -1;
      for (int k = 0; k < NREQ; k++)
        if (w < 0 && rq[(ptr_m + k) % NREQ]) w = (ptr_m + k) % NREQ;
      sw = s[w*WIDTH +: WIDTH];
      rw = r[w*WIDTH +: WIDTH];
      ee = 1'b0;
      for (int b = 0; b < WIDTH; b++) begin
        case ({sw[b], rw[b]})
          2'b10:   q_m[b] = 1'b1;
          2'b01:   q_m[b] = 1'b0;
          2'b11:   ee = 1'b1;
          default: ;
        endcase
      end
      app_f = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      if (app_f[1])      q_m = 4'h0;
      else if (app_f[0]) q_m = 4'hf;
      run_txn(rq, s, r, 3'(1 << w), q_m, ee, 1'b1, app_f);
      ptr_m = (w + 1) % NREQ;
    end

    running = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
